// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the shared-multiplier arbiter: id width helper,
// default widths and the response record layout.
package mul_share_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_IA_W  = 16;
    localparam int DEF_IB_W  = 16;
    localparam int DEF_MUL_W = DEF_IA_W + DEF_IB_W;

    // Bits needed to encode a requester index; never less than one.
    function automatic int id_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_ID_W = id_width(DEF_N_REQ);

    typedef struct packed {
        logic [DEF_MUL_W-1:0] prod;
        logic [DEF_ID_W-1:0]  id;
        logic                 valid;
    } rsp_t;

endpackage

// File: rtl/array_mul.sv
// Combinational array multiplier core. Signed mode works on sign-magnitude
// internally, so the most-negative operand encodings are outside its range.
module array_mul #(
    parameter int IA_W        = 16,
    parameter int IB_W        = 16,
    parameter int SIGNED      = 0,
    parameter int APPROX_TYPE = 0,
    parameter int VBL         = 0,
    parameter int HBL         = 0,
    localparam int P_W        = IA_W + IB_W
) (
    input  logic [IA_W-1:0] i_a,
    input  logic [IB_W-1:0] i_b,
    input  logic            i_en_ff,
    output logic [P_W-1:0]  o_prod
);

    logic            sign_a;
    logic            sign_b;
    logic [IA_W-1:0] mag_a;
    logic [IB_W-1:0] mag_b;
    logic [P_W-1:0]  mag_p;
    logic [P_W-1:0]  col_mask;

    always_comb begin
        sign_a = (SIGNED != 0) && i_a[IA_W-1];
        sign_b = (SIGNED != 0) && i_b[IB_W-1];
        mag_a  = sign_a ? -i_a : i_a;
        mag_b  = sign_b ? -i_b : i_b;
        // Approximate modes drop the HBL low partial-product rows and VBL low columns.
        if (APPROX_TYPE != 0) mag_b = mag_b & ({IB_W{1'b1}} << HBL);
        col_mask = (APPROX_TYPE != 0) ? ({P_W{1'b1}} << VBL) : {P_W{1'b1}};
        mag_p    = (P_W'(mag_a) * P_W'(mag_b)) & col_mask;
        o_prod   = '0;
        if (i_en_ff) o_prod = (sign_a ^ sign_b) ? -mag_p : mag_p;
    end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter: searches circularly from the last granted index + 1
// and advances its pointer only when it issues a grant.
module mul_rr_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              cand;
    logic [ID_W-1:0] cidx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            cidx = ID_W'(cand);
            if (i_en && !found && i_req[cidx]) begin
                found         = 1'b1;
                o_grant[cidx] = 1'b1;
                o_idx         = cidx;
            end
        end
    end

    // Every grant targets a valid requester, so a grant is always a transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr <= ID_W'(N_REQ - 1);
        else if (found) ptr <= o_idx;
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one array multiplier among N_REQ requesters: round-robin grant,
// MUL_LAT-deep product pipeline, single valid/ready response tagged by id.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int IA_W        = 16,
    parameter int IB_W        = 16,
    parameter int MUL_W       = 32,
    parameter int SIGNED      = 0,
    parameter int APPROX_TYPE = 0,
    parameter int VBL         = 0,
    parameter int HBL         = 0,
    parameter int MUL_LAT     = 2,
    localparam int ID_W       = id_width(N_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ-1:0][IA_W-1:0] i_req_a,
    input  logic [N_REQ-1:0][IB_W-1:0] i_req_b,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [MUL_W-1:0]           o_rsp_prod,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic                       o_busy
);

    logic                   stall;
    logic                   arb_en;
    logic                   xfer;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        gidx;
    logic [IA_W-1:0]        a_sel;
    logic [IB_W-1:0]        b_sel;
    logic [IA_W+IB_W-1:0]   mul_prod;

    logic [MUL_LAT:1]       vld_p;
    logic [MUL_W-1:0]       prod_p [1:MUL_LAT];
    logic [ID_W-1:0]        id_p   [1:MUL_LAT];

    // A stalled output freezes every stage, so nothing may be granted.
    assign stall  = vld_p[MUL_LAT] & ~i_rsp_ready;
    assign arb_en = ~stall & ~i_flush & ~i_rst;

    mul_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req_valid),
        .i_en    (arb_en),
        .o_grant (grant),
        .o_idx   (gidx)
    );

    assign o_req_ready = grant;
    assign xfer        = |(i_req_valid & grant);
    assign a_sel       = i_req_a[gidx];
    assign b_sel       = i_req_b[gidx];

    array_mul #(
        .IA_W        (IA_W),
        .IB_W        (IB_W),
        .SIGNED      (SIGNED),
        .APPROX_TYPE (APPROX_TYPE),
        .VBL         (VBL),
        .HBL         (HBL)
    ) u_mul (
        .i_a     (a_sel),
        .i_b     (b_sel),
        .i_en_ff (1'b1),
        .o_prod  (mul_prod)
    );

    // Stage 1 captures the product; stages 2..MUL_LAT shift it toward the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p <= '0;
            for (int s = 1; s <= MUL_LAT; s++) begin
                prod_p[s] <= '0;
                id_p[s]   <= '0;
            end
        end else if (i_flush) begin
            vld_p <= '0;
        end else if (!stall) begin
            vld_p[1]  <= xfer;
            prod_p[1] <= MUL_W'(mul_prod);
            id_p[1]   <= gidx;
            for (int s = 2; s <= MUL_LAT; s++) begin
                vld_p[s]  <= vld_p[s-1];
                prod_p[s] <= prod_p[s-1];
                id_p[s]   <= id_p[s-1];
            end
        end
    end

    assign o_rsp_valid = vld_p[MUL_LAT];
    assign o_rsp_prod  = prod_p[MUL_LAT];
    assign o_rsp_id    = id_p[MUL_LAT];
    assign o_busy      = |vld_p;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: an unsigned and a signed instance
// share one stimulus stream and are checked against a transaction-level model.
module tb_mul_share_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int BW  = 8;
    localparam int PW  = 16;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic rsp_ready;
    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] req_a;
    logic [N-1:0][BW-1:0] req_b;

    logic [N-1:0]   rdy_u, rdy_s;
    logic           vld_u, vld_s;
    logic [PW-1:0]  prod_u, prod_s;
    logic [IDW-1:0] id_u, id_s;
    logic           busy_u, busy_s;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .N_REQ(N), .IA_W(AW), .IB_W(BW), .MUL_W(PW), .SIGNED(0),
        .APPROX_TYPE(0), .VBL(0), .HBL(0), .MUL_LAT(LAT)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_req_valid(req_valid),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(rdy_u), .o_rsp_valid(vld_u),
        .i_rsp_ready(rsp_ready), .o_rsp_prod(prod_u), .o_rsp_id(id_u), .o_busy(busy_u)
    );

    mul_share_arbiter #(
        .N_REQ(N), .IA_W(AW), .IB_W(BW), .MUL_W(PW), .SIGNED(1),
        .APPROX_TYPE(0), .VBL(0), .HBL(0), .MUL_LAT(LAT)
    ) s_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_req_valid(req_valid),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(rdy_s), .o_rsp_valid(vld_s),
        .i_rsp_ready(rsp_ready), .o_rsp_prod(prod_s), .o_rsp_id(id_s), .o_busy(busy_s)
    );

    typedef struct {
        int         id;
        int         age;
        logic [15:0] pu;
        logic [15:0] ps;
    } ent_t;

    ent_t         q[$];
    int           mptr = N - 1;
    logic [N-1:0] xfer_last = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return 16'(sa * sb);
    endfunction

    function automatic logic [7:0] rand_op();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == 8'h80);
        return v;
    endfunction

    task automatic newop(input int i);
        req_a[i] = rand_op();
        req_b[i] = rand_op();
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) if (xfer_last[i]) newop(i);
    endtask

    // Transaction model: each accepted operand pair ages one step per
    // unstalled edge and is due at the output once it has aged LAT steps.
    always @(negedge clk) begin : cmp
        logic         exp_v;
        logic         stl;
        logic [N-1:0] exp_rdy;
        logic [1:0]   ci;
        int           gi;
        ent_t         e;
        if (rst) begin
            chk("rst_ready_u", 32'(rdy_u), 32'd0);
            chk("rst_valid_u", 32'(vld_u), 32'd0);
            chk("rst_prod_u",  32'(prod_u), 32'd0);
            chk("rst_id_u",    32'(id_u), 32'd0);
            chk("rst_busy_u",  32'(busy_u), 32'd0);
            chk("rst_ready_s", 32'(rdy_s), 32'd0);
            chk("rst_valid_s", 32'(vld_s), 32'd0);
            q.delete();
            mptr = N - 1;
            xfer_last = '0;
        end else begin
            exp_v   = (q.size() > 0) && (q[0].age == LAT);
            stl     = exp_v && !rsp_ready;
            exp_rdy = '0;
            gi      = 0;
            if (!stl && !flush) begin
                for (int k = 1; k <= N; k++) begin
                    ci = 2'((mptr + k) % N);
                    if (exp_rdy == '0 && req_valid[ci]) begin
                        exp_rdy[ci] = 1'b1;
                        gi = int'(ci);
                    end
                end
            end
            chk("ready_u", 32'(rdy_u), 32'(exp_rdy));
            chk("ready_s", 32'(rdy_s), 32'(exp_rdy));
            chk("valid_u", 32'(vld_u), 32'(exp_v));
            chk("valid_s", 32'(vld_s), 32'(exp_v));
            chk("busy_u",  32'(busy_u), 32'(q.size() > 0));
            chk("busy_s",  32'(busy_s), 32'(q.size() > 0));
            if (exp_v) begin
                chk("prod_u", 32'(prod_u), 32'(q[0].pu));
                chk("prod_s", 32'(prod_s), 32'(q[0].ps));
                chk("id_u",   32'(id_u), 32'(q[0].id));
                chk("id_s",   32'(id_s), 32'(q[0].id));
            end
            xfer_last = req_valid & exp_rdy;
            if (flush) begin
                q.delete();
            end else if (!stl) begin
                if (exp_v) void'(q.pop_front());
                foreach (q[j]) q[j].age++;
                if (xfer_last != '0) begin
                    e.id  = gi;
                    e.age = 1;
                    e.pu  = 16'(req_a[gi]) * 16'(req_b[gi]);
                    e.ps  = smul(req_a[gi], req_b[gi]);
                    q.push_back(e);
                    mptr = gi;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(rdy_u), 32'd0);
        chk("async_rst_valid", 32'(vld_u), 32'd0);
        chk("async_rst_prod",  32'(prod_u), 32'd0);
        chk("async_rst_id",    32'(id_u), 32'd0);
        chk("async_rst_busy",  32'(busy_u), 32'd0);
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request: 12 * 13 from requester 0.
        req_valid = 4'b0001; req_a[0] = 8'd12; req_b[0] = 8'd13;
        #1;
        chk("single_grant", 32'(rdy_u), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        chk("single_busy_t1", 32'(busy_u), 32'd1);
        chk("single_valid_t1", 32'(vld_u), 32'd0);
        @(posedge clk); #1;
        chk("single_valid_t2", 32'(vld_u), 32'd1);
        chk("single_prod", 32'(prod_u), 32'd156);
        chk("single_id", 32'(id_u), 32'd0);
        chk("single_busy_t2", 32'(busy_u), 32'd1);
        @(posedge clk); #1;
        chk("single_idle", 32'(busy_u), 32'd0);

        // All requesters held valid: strict rotation from requester 0.
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) newop(i);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(rdy_u), 32'(1 << (k % 4)));
            @(posedge clk); #1;
            refresh();
        end

        // Full pipeline, consumer stalls for three cycles.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(rdy_u), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            refresh();
        end

        // Flush with two operations in flight.
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(rdy_u), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", 32'(vld_u), 32'd0);
        chk("flush_busy", 32'(busy_u), 32'd0);
        #1;
        chk("flush_next_grant", 32'(rdy_u), 32'(1 << ((mptr + 1) % N)));

        // Signed products: -3*5 and -3*-2.
        do_reset();
        req_valid = 4'b0011;
        req_a[0] = 8'hFD; req_b[0] = 8'h05;
        req_a[1] = 8'hFD; req_b[1] = 8'hFE;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("signed_valid0", 32'(vld_s), 32'd1);
        chk("signed_prod0", 32'(prod_s), 32'h0000FFF1);
        chk("signed_id0", 32'(id_s), 32'd0);
        chk("unsigned_prod0", 32'(prod_u), 32'h000004F1);
        @(posedge clk); #1;
        chk("signed_prod1", 32'(prod_s), 32'h00000006);
        chk("signed_id1", 32'(id_s), 32'd1);
        chk("unsigned_prod1", 32'(prod_u), 32'h0000FB06);

        // Asynchronous reset in the middle of a stream.
        req_valid = '1;
        for (int i = 0; i < N; i++) newop(i);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            refresh();
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(rdy_u), 32'd0);
        chk("mid_rst_valid", 32'(vld_u), 32'd0);
        chk("mid_rst_prod", 32'(prod_u), 32'd0);
        chk("mid_rst_busy", 32'(busy_u), 32'd0);
        chk("mid_rst_prod_s", 32'(prod_s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(rdy_u), 32'h1);

        // Randomized traffic with back-pressure and occasional flushes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (xfer_last[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_valid[i] = 1'b1;
                        newop(i);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
        end

        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
